// File: rtl/pq_dispatch_pkg.sv
// pq_dispatch_pkg
// Shared definitions for the priority-queue drain controller: default widths,
// the default dequeue spacing, the gap counter width and the FSM state encoding.
// No ports; imported by every file of the pq_dispatch slice.

package pq_dispatch_pkg;

  localparam int DWIDTH_DEFAULT  = 16;
  localparam int HDEPTH_DEFAULT  = 5;
  localparam int DEQ_GAP_DEFAULT = 2;

  // Wide enough for the largest legal DEQ_GAP-1 (14).
  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/pq_dispatch_if.sv
// pq_dispatch_if
// Bundles the queue-side pop interface and the downstream event handshake.
//   q_count    : queue occupancy (queue -> dispatcher)
//   q_out_data : queue head / minimum timestamp (queue -> dispatcher)
//   q_deq      : one-cycle pop strobe (dispatcher -> queue)
//   ev_vld     : buffered event available (dispatcher -> core)
//   ev_data    : event at buffer head (dispatcher -> core)
//   ev_rdy     : core accepts the event (core -> dispatcher)
// Modports: master = dispatcher view, slave = queue/core environment view.

interface pq_dispatch_if import pq_dispatch_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEFAULT,
  parameter int HDEPTH = HDEPTH_DEFAULT
);

  logic [HDEPTH-1:0] q_count;
  logic [DWIDTH-1:0] q_out_data;
  logic              q_deq;
  logic              ev_vld;
  logic [DWIDTH-1:0] ev_data;
  logic              ev_rdy;

  modport master (
    input  q_count, q_out_data, ev_rdy,
    output q_deq, ev_vld, ev_data
  );

  modport slave (
    output q_count, q_out_data, ev_rdy,
    input  q_deq, ev_vld, ev_data
  );

endinterface

// File: rtl/pq_dispatch_buf.sv
// pq_dispatch_buf
// Two-entry event FIFO between the queue pop path and the downstream handshake.
// Accepts a push and a pop on the same edge (occupancy unchanged, order kept)
// and has a synchronous clear that takes priority over everything else.
//   CLK, rst  : clock, asynchronous active-high reset
//   clear     : synchronous flush of all entries
//   push      : write push_data at the tail
//   push_data : event word to store
//   pop       : remove head (ignored when empty)
//   vld       : FIFO non-empty
//   head_data : head entry, 0 when empty
//   occ       : current occupancy (0..2)

module pq_dispatch_buf import pq_dispatch_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic              vld,
  output logic [DWIDTH-1:0] head_data,
  output logic [1:0]        occ
);

  logic [DWIDTH-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_pop;
  logic              do_push;

  // A pop only counts when something is stored; a push into a full FIFO is
  // accepted only if the head leaves on the same edge.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Storage, pointers and occupancy. Clear resets the pointers so the next
  // push lands in entry 0 again; stale data in mem is never shown because
  // head_data is masked while empty.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign vld       = (count != 2'd0);
  assign head_data = vld ? mem[rd_ptr] : '0;
  assign occ       = count;

endmodule

// File: rtl/pq_dispatch.sv
// pq_dispatch
// Drain-side controller for the PDES event priority queue. Pops the minimum
// event whenever it is eligible (queue non-empty, no flush, buffer room, and
// inside the conservative time window), spaces pops by DEQ_GAP cycles to let
// the queue re-heapify, and hands events downstream through a 2-entry buffer.
//   CLK, rst  : clock, asynchronous active-high reset
//   bus       : queue pop interface + downstream valid/ready (master view)
//   win_en    : apply the time window when 1
//   win_limit : inclusive upper timestamp bound (unsigned)
//   flush     : inhibit new pops and discard buffered events while high
//   busy      : FSM not idle or buffer holds an event
//   disp_cnt  : wrapping count of events accepted downstream

module pq_dispatch import pq_dispatch_pkg::*; #(
  parameter int DWIDTH  = DWIDTH_DEFAULT,
  parameter int HDEPTH  = HDEPTH_DEFAULT,
  parameter int DEQ_GAP = DEQ_GAP_DEFAULT
) (
  input  logic              CLK,
  input  logic              rst,
  pq_dispatch_if.master     bus,
  input  logic              win_en,
  input  logic [DWIDTH-1:0] win_limit,
  input  logic              flush,
  output logic              busy,
  output logic [31:0]       disp_cnt
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(DEQ_GAP - 1);

  state_t               state;
  state_t               next_state;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [GAP_CNT_W-1:0] gap_next;
  logic                 q_deq_r;
  logic                 in_window;
  logic                 elig;
  logic                 push;
  logic                 fire;
  logic                 buf_vld;
  logic [DWIDTH-1:0]    buf_head;
  logic [1:0]           buf_occ;

  // The head is only trusted in IDLE; during POP/GAP the queue is reshuffling
  // its heap, so eligibility is consumed by the FSM in IDLE alone.
  assign in_window = !win_en || (bus.q_out_data <= win_limit);
  assign elig      = (bus.q_count != HDEPTH'(0)) && !flush &&
                     (buf_occ < 2'd2) && in_window;

  // Next-state logic. POP always lasts one cycle and loads the gap counter;
  // GAP counts down and returns to IDLE on the cycle the counter would reach
  // zero, so pops are DEQ_GAP+1 cycles apart including the IDLE evaluation.
  always_comb begin
    next_state = state;
    gap_next   = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (elig) begin
          next_state = ST_POP;
        end
      end
      ST_POP: begin
        gap_next   = GAP_LOAD;
        next_state = (DEQ_GAP > 1) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        gap_next = gap_cnt - GAP_CNT_W'(1);
        if (gap_cnt <= GAP_CNT_W'(1)) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register. q_deq is registered alongside the state so it is a clean
  // decode of POP and drops immediately when reset is asserted.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      q_deq_r <= 1'b0;
    end else begin
      state   <= next_state;
      gap_cnt <= gap_next;
      q_deq_r <= (next_state == ST_POP);
    end
  end

  // The popped head is captured on the edge that ends the POP cycle. Flush
  // clears the buffer on the same edge, which discards a capture in flight.
  assign push = (state == ST_POP);

  pq_dispatch_buf #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .CLK       (CLK),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (bus.q_out_data),
    .pop       (bus.ev_rdy),
    .vld       (buf_vld),
    .head_data (buf_head),
    .occ       (buf_occ)
  );

  assign bus.q_deq   = q_deq_r;
  assign bus.ev_vld  = buf_vld;
  assign bus.ev_data = buf_head;
  assign fire        = buf_vld && bus.ev_rdy;

  // Count every downstream acceptance; the counter wraps naturally.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      disp_cnt <= 32'd0;
    end else if (fire) begin
      disp_cnt <= disp_cnt + 32'd1;
    end
  end

  assign busy = (state != ST_IDLE) || buf_vld;

endmodule

// File: tb/tb_pq_dispatch.sv
// tb_pq_dispatch
// Self-checking bench for pq_dispatch. A sorted-array queue model feeds the
// DUT and reacts to q_deq; a timing-rule reference model predicts q_deq,
// ev_vld, ev_data, busy and disp_cnt every cycle. Directed scenarios pin the
// model with literal expectations, then a randomized phase runs against it.

module tb_pq_dispatch;
  import pq_dispatch_pkg::*;

  localparam int DW  = DWIDTH_DEFAULT;
  localparam int HD  = HDEPTH_DEFAULT;
  localparam int GAP = DEQ_GAP_DEFAULT;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          win_en = 1'b0;
  logic [DW-1:0] win_limit = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic [31:0]   disp_cnt;

  pq_dispatch_if bus ();

  pq_dispatch #(
    .DWIDTH  (DW),
    .HDEPTH  (HD),
    .DEQ_GAP (GAP)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .bus       (bus),
    .win_en    (win_en),
    .win_limit (win_limit),
    .flush     (flush),
    .busy      (busy),
    .disp_cnt  (disp_cnt)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Queue environment: sorted ascending, head = minimum.
  int unsigned envq[$];
  bit          env_deq = 1'b0;

  // Logs of what the DUT actually did, for the literal checks.
  int unsigned got[$];
  int          got_cyc[$];
  int          deq_cyc[$];

  // Reference model state.
  int unsigned mfifo[$];
  bit          m_deq      = 1'b0;
  bit          m_popped   = 1'b0;
  int          m_last_pop = 0;
  logic [31:0] m_cnt      = 32'd0;

  // One comparison: steps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkGot(input string name, input int idx, input int unsigned exp);
    if (idx < got.size()) begin
      checkOutput(name, got[idx], exp);
    end else begin
      checkOutput(name, 32'hFFFF_FFFF, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic fl,
                               input logic we, input logic [DW-1:0] wl);
    bus.ev_rdy = rdy;
    flush      = fl;
    win_en     = we;
    win_limit  = wl;
  endtask

  task automatic envInsert(input int unsigned v);
    int i = 0;
    while (i < envq.size() && envq[i] <= v) i++;
    envq.insert(i, v);
  endtask

  task automatic envDrive();
    bus.q_count    = HD'(envq.size());
    bus.q_out_data = (envq.size() != 0) ? DW'(envq[0]) : '0;
  endtask

  task automatic clearLogs();
    got.delete();
    got_cyc.delete();
    deq_cyc.delete();
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Queue environment: removes the head after every edge that ended a cycle
  // with q_deq high, then presents the new occupancy and minimum.
  initial begin
    envDrive();
    forever begin
      @(posedge CLK);
      #2;
      if (env_deq && envq.size() != 0) void'(envq.pop_front());
      envDrive();
    end
  end

  // Compare process: checks the DUT against the model mid-cycle, then
  // advances the model by one cycle from the inputs seen in this cycle.
  // Rules: a pop happens the cycle after an idle cycle in which the head was
  // eligible; a cycle is idle once DEQ_GAP cycles have passed since the last
  // pop; the popped head enters the buffer, handshakes drain it, flush empties it.
  always @(negedge CLK) begin : compare_proc
    logic        exp_vld;
    logic [31:0] exp_data;
    logic        exp_busy;
    logic        idle;
    logic        elig;
    cyc++;
    env_deq = bus.q_deq && !rst;
    if (rst) begin
      mfifo.delete();
      m_deq    = 1'b0;
      m_popped = 1'b0;
      m_cnt    = 32'd0;
      checkOutput("rst_q_deq", 32'(bus.q_deq), 32'd0);
      checkOutput("rst_ev_vld", 32'(bus.ev_vld), 32'd0);
      checkOutput("rst_ev_data", 32'(bus.ev_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_disp_cnt", disp_cnt, 32'd0);
    end else begin
      exp_vld  = (mfifo.size() != 0);
      exp_data = exp_vld ? mfifo[0] : 32'd0;
      exp_busy = exp_vld || (m_popped && (cyc - m_last_pop) < GAP);
      checkOutput("q_deq", 32'(bus.q_deq), 32'(m_deq));
      checkOutput("ev_vld", 32'(bus.ev_vld), 32'(exp_vld));
      checkOutput("ev_data", 32'(bus.ev_data), exp_data);
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("disp_cnt", disp_cnt, m_cnt);

      if (bus.q_deq) deq_cyc.push_back(cyc);
      if (bus.ev_vld && bus.ev_rdy) begin
        got.push_back(32'(bus.ev_data));
        got_cyc.push_back(cyc);
      end

      idle = !m_popped || ((cyc - m_last_pop) >= GAP);
      elig = (bus.q_count != 0) && !flush && (mfifo.size() < 2) &&
             (!win_en || (bus.q_out_data <= win_limit));

      if (exp_vld && bus.ev_rdy) begin
        m_cnt = m_cnt + 32'd1;
        void'(mfifo.pop_front());
      end
      if (m_deq) mfifo.push_back(32'(bus.q_out_data));
      if (flush) mfifo.delete();

      m_deq = idle && elig;
      if (m_deq) begin
        m_popped   = 1'b1;
        m_last_pop = cyc + 1;
      end
    end
  end

  initial begin : main
    int rel_cyc;
    int ndeq;
    logic [31:0] cnt0;
    bit found;

    // Reset with a populated queue and a ready consumer.
    bus.ev_rdy = 1'b1;
    envInsert(7);
    envInsert(20);
    envInsert(30);
    runCycles(3);
    clearLogs();
    rst = 1'b0;
    rel_cyc = cyc;
    runCycles(12);
    $display("[TB] reset release and first pop");
    checkOutput("t1_first_deq_latency", deq_cyc.size() > 0 ? deq_cyc[0] - rel_cyc : -1, 2);
    checkGot("t1_first_event", 0, 7);
    checkOutput("t1_first_vld_latency", got_cyc.size() > 0 ? got_cyc[0] - rel_cyc : -1, 3);
    checkOutput("t1_disp_cnt", disp_cnt, 3);

    // In-order dispatch with DEQ_GAP spacing.
    clearLogs();
    cnt0 = disp_cnt;
    envInsert(12);
    envInsert(4);
    envInsert(9);
    runCycles(15);
    $display("[TB] ordered dispatch");
    checkGot("t2_ev0", 0, 4);
    checkGot("t2_ev1", 1, 9);
    checkGot("t2_ev2", 2, 12);
    checkOutput("t2_deq_count", deq_cyc.size(), 3);
    checkOutput("t2_spacing01", deq_cyc.size() > 1 ? deq_cyc[1] - deq_cyc[0] : 0, 3);
    checkOutput("t2_spacing12", deq_cyc.size() > 2 ? deq_cyc[2] - deq_cyc[1] : 0, 3);
    checkOutput("t2_disp_delta", disp_cnt - cnt0, 3);

    // Backpressure: buffer fills at two entries, pops stop.
    clearLogs();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    envInsert(1);
    envInsert(2);
    envInsert(3);
    envInsert(5);
    runCycles(15);
    $display("[TB] backpressure");
    checkOutput("t3_deq_count", deq_cyc.size(), 2);
    checkOutput("t3_head", 32'(bus.ev_data), 1);
    checkOutput("t3_queue_left", envq.size(), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    runCycles(20);
    checkGot("t3_ev0", 0, 1);
    checkGot("t3_ev1", 1, 2);
    checkGot("t3_ev2", 2, 3);
    checkGot("t3_ev3", 3, 5);

    // Time window, including a head exactly at the limit.
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b1, DW'(10));
    envInsert(8);
    envInsert(10);
    envInsert(11);
    runCycles(15);
    $display("[TB] time window");
    checkOutput("t4_count", got.size(), 2);
    checkGot("t4_ev0", 0, 8);
    checkGot("t4_ev1", 1, 10);
    checkOutput("t4_stalled", envq.size(), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, DW'(11));
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(posedge CLK);
      #2;
      if (bus.q_deq) found = 1'b1;
    end
    checkOutput("t4_pop_after_raise", 32'(found), 1);
    runCycles(5);
    checkGot("t4_ev2", 2, 11);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Flush with a full buffer.
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    envInsert(3);
    envInsert(6);
    envInsert(9);
    envInsert(15);
    runCycles(10);
    $display("[TB] flush");
    checkOutput("t5_full_vld", 32'(bus.ev_vld), 1);
    checkOutput("t5_full_head", 32'(bus.ev_data), 3);
    clearLogs();
    cnt0 = disp_cnt;
    ndeq = deq_cyc.size();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    runCycles(1);
    checkOutput("t5_vld_cleared", 32'(bus.ev_vld), 0);
    runCycles(2);
    checkOutput("t5_no_deq", deq_cyc.size(), ndeq);
    checkOutput("t5_cnt_held", disp_cnt, cnt0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    runCycles(15);
    checkGot("t5_resume0", 0, 9);
    checkGot("t5_resume1", 1, 15);

    // Reset in the middle of a pop.
    clearLogs();
    envInsert(2);
    envInsert(4);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge CLK);
      #2;
      if (bus.q_deq) found = 1'b1;
    end
    $display("[TB] reset during pop");
    checkOutput("t6_deq_seen", 32'(found), 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_async_q_deq", 32'(bus.q_deq), 0);
    checkOutput("t6_ev_vld", 32'(bus.ev_vld), 0);
    checkOutput("t6_disp_cnt", disp_cnt, 0);
    checkOutput("t6_busy", 32'(busy), 0);
    runCycles(2);
    rst = 1'b0;
    runCycles(12);
    checkGot("t6_after0", 0, 2);
    checkGot("t6_after1", 1, 4);
    checkOutput("t6_disp_cnt_after", disp_cnt, 2);

    // Randomized traffic against the reference model.
    $display("[TB] random phase");
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0 && envq.size() < 24) envInsert($urandom_range(63));
      bus.ev_rdy = ($urandom_range(2) != 0);
      flush      = ($urandom_range(15) == 0);
      if ($urandom_range(31) == 0) win_en = $urandom_range(1);
      if ($urandom_range(7) == 0) win_limit = DW'($urandom_range(63));
      runCycles(1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    runCycles(100);
    checkOutput("rand_drained", envq.size(), 0);
    checkOutput("rand_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
